ddr_cmd_decoder: RTL

- Upstream stage of the per-bank timing FSM array: samples raw DDR4 command/address pins every clk.
- Decodes them into one-cycle, one-hot command pulses plus registered bank-group/bank/address, matching the ACT..WRA strobe set the bank FSM array consumes.
- Tracks CKE history and the device power state so that PD, PDX, SRF, CKEH and CKEL are derived correctly.
- Flags illegal or reserved commands in a saturating error counter.

---
 rtl/ddr_cmd_pkg.sv | 59 +++++
 rtl/ddr_cmd_decoder_parity.sv | 31 +++
 rtl/ddr_cmd_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared types and encodings for the DDR4 command decoder.
// Build macro CMDDEC_CA_PARITY_EN enables CA parity checking in the top.
package ddr_cmd_pkg;

   typedef enum logic [1:0] {
      ACTIVE  = 2'd0,
      PWRDN   = 2'd1,
      SELFREF = 2'd2
   } pwr_state_t;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_ACT,
      CMD_MRW,
      CMD_REF,
      CMD_PR,
      CMD_PRA,
      CMD_WR,
      CMD_WRA,
      CMD_RD,
      CMD_RDA,
      CMD_CFG,
      CMD_RSVD
   } cmd_t;

   // {ras_n, cas_n, we_n} encodings when act_n is high
   localparam logic [2:0] RCW_MRW  = 3'b000;
   localparam logic [2:0] RCW_REF  = 3'b001;
   localparam logic [2:0] RCW_PR   = 3'b010;
   localparam logic [2:0] RCW_RSVD = 3'b011;
   localparam logic [2:0] RCW_WR   = 3'b100;
   localparam logic [2:0] RCW_RD   = 3'b101;
   localparam logic [2:0] RCW_CFG  = 3'b110;
   localparam logic [2:0] RCW_NOP  = 3'b111;

   localparam int A10_BIT = 10;

   function automatic cmd_t decode_cmd(input logic act_n, input logic [2:0] rcw,
                                       input logic a10);
      cmd_t c;
      c = CMD_RSVD;
      if (!act_n) begin
         c = CMD_ACT;
      end else begin
         case (rcw)
            RCW_MRW:  c = CMD_MRW;
            RCW_REF:  c = CMD_REF;
            RCW_PR:   c = a10 ? CMD_PRA : CMD_PR;
            RCW_RSVD: c = CMD_RSVD;
            RCW_WR:   c = a10 ? CMD_WRA : CMD_WR;
            RCW_RD:   c = a10 ? CMD_RDA : CMD_RD;
            RCW_CFG:  c = CMD_CFG;
            default:  c = CMD_NOP;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/ddr_cmd_decoder_parity.sv
// CA parity compare and alert_n stretcher; used only when CMDDEC_CA_PARITY_EN is defined.
// alert_n stays low for 4 cycles after the last parity error (retriggerable).
module ddr_ca_parity #(
   parameter int DW = 22
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cs_n,
   input  logic [DW-1:0] ca,
   input  logic          par,
   output logic          par_err,
   output logic          alert_n
);

   logic [2:0] stretch;

   // even parity: CA bits plus par must XOR to zero
   assign par_err = ~cs_n & (^{ca, par});
   assign alert_n = (stretch == 3'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stretch <= 3'd0;
      end else if (par_err) begin
         stretch <= 3'd4;
      end else if (stretch != 3'd0) begin
         stretch <= stretch - 3'd1;
      end
   end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR4 command/address decoder: one-cycle command pulses, CKE/power-state tracking,
// saturating illegal-command counter. Optional CA parity under CMDDEC_CA_PARITY_EN.
module ddr_cmd_decoder
   import ddr_cmd_pkg::*;
#(
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int ADDRWIDTH = 14,
   parameter int ERRWIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cke,
   input  logic                 cs_n,
   input  logic                 act_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 we_n,
   input  logic [BGWIDTH-1:0]   bg,
   input  logic [BAWIDTH-1:0]   ba,
   input  logic [ADDRWIDTH-1:0] addr,
`ifdef CMDDEC_CA_PARITY_EN
   input  logic                 par,
   output logic                 alert_n,
`endif
   output logic [BGWIDTH-1:0]   bg_q,
   output logic [BAWIDTH-1:0]   ba_q,
   output logic [ADDRWIDTH-1:0] addr_q,
   output logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW,
   output logic PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA,
   output logic [1:0]           pwr_state,
   output logic [ERRWIDTH-1:0]  err_cnt
);

   pwr_state_t ps;
   logic       cke_prev;
   cmd_t       cmd;
   logic       sel, cke_fall, cke_rise, decode_en, non_nop, err_inc, par_err;

`ifdef CMDDEC_CA_PARITY_EN
   ddr_ca_parity #(.DW(4 + BGWIDTH + BAWIDTH + ADDRWIDTH)) u_parity (
      .clk     (clk),
      .reset_n (reset_n),
      .cs_n    (cs_n),
      .ca      ({act_n, ras_n, cas_n, we_n, bg, ba, addr}),
      .par     (par),
      .par_err (par_err),
      .alert_n (alert_n)
   );
`else
   assign par_err = 1'b0;
`endif

   // LPDDR-only strobes never fire on a DDR4 device
   assign BST  = 1'b0;
   assign DPD  = 1'b0;
   assign DPDX = 1'b0;
   assign MRR  = 1'b0;

   assign pwr_state = ps;

   always_comb begin
      cmd       = decode_cmd(act_n, {ras_n, cas_n, we_n}, addr[A10_BIT]);
      sel       = ~cs_n;
      cke_fall  = cke_prev & ~cke;
      cke_rise  = ~cke_prev & cke;
      decode_en = sel && cke_prev && cke && (ps == ACTIVE) && !par_err;
      non_nop   = sel && (cmd != CMD_NOP);
      err_inc   = par_err;
      if (ps == ACTIVE) begin
         // a command other than REF/NOP on the CKE-low edge is dropped and counted
         if (cke_fall) begin
            err_inc = par_err || (non_nop && (cmd != CMD_REF));
         end else if (decode_en && (cmd == CMD_RSVD)) begin
            err_inc = 1'b1;
         end
      end else begin
         err_inc = par_err || non_nop;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps       <= ACTIVE;
         cke_prev <= 1'b1;
         err_cnt  <= '0;
         bg_q     <= '0;
         ba_q     <= '0;
         addr_q   <= '0;
         {ACT, CFG, CKEH, CKEL, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA} <= '0;
      end else begin
         {ACT, CFG, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA} <= '0;
         cke_prev <= cke;
         CKEL     <= cke_fall;
         CKEH     <= cke_rise;
         if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERRWIDTH'(1);
         end
         case (ps)
            ACTIVE: begin
               if (cke_fall) begin
                  if (sel && (cmd == CMD_REF)) begin
                     SRF <= 1'b1;
                     ps  <= SELFREF;
                  end else begin
                     PD  <= 1'b1;
                     ps  <= PWRDN;
                  end
               end else if (decode_en) begin
                  case (cmd)
                     CMD_ACT: ACT <= 1'b1;
                     CMD_MRW: MRW <= 1'b1;
                     CMD_REF: REF <= 1'b1;
                     CMD_PR:  PR  <= 1'b1;
                     CMD_PRA: PRA <= 1'b1;
                     CMD_WR:  WR  <= 1'b1;
                     CMD_WRA: WRA <= 1'b1;
                     CMD_RD:  RD  <= 1'b1;
                     CMD_RDA: RDA <= 1'b1;
                     CMD_CFG: CFG <= 1'b1;
                     default: ;
                  endcase
                  if ((cmd != CMD_NOP) && (cmd != CMD_RSVD)) begin
                     bg_q   <= bg;
                     ba_q   <= ba;
                     addr_q <= addr;
                  end
               end
            end
            default: begin
               if (cke) begin
                  PDX <= 1'b1;
                  ps  <= ACTIVE;
               end
            end
         endcase
      end
   end

endmodule
